rc_gearbox256: RTL and testbench

RC_GEARBOX256 -- requirements
Module: rc_gearbox256

---
 rtl/rc_gearbox_pkg.sv | 37 +++
 rtl/rc_gearbox256_if.sv | 37 +++
 rtl/rc_gearbox256.sv | 147 ++++++++++++++
 tb/tb_rc_gearbox256.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc_gearbox_pkg.sv
// rc_gearbox_pkg: shared constants, FSM states and dword-count helpers for rc_gearbox256
//   descriptor field offsets (bit positions within the first 96 bits of the first beat),
//   state_t (IDLE/BODY/FLUSH), norm_count (D=0 means 1024), tail_keep, needs_flush
package rc_gearbox_pkg;

    localparam int BEAT_W   = 256;
    localparam int TUSER_W  = 75;
    localparam int KEEP_W   = 8;
    localparam int HDR_W    = 96;
    localparam int EC_LSB   = 12;
    localparam int EC_W     = 4;
    localparam int CNT_LSB  = 32;
    localparam int CNT_W    = 11;
    localparam int ST_LSB   = 43;
    localparam int ST_W     = 3;
    localparam int POIS_BIT = 46;
    localparam int TAG_LSB  = 64;
    localparam int TAG_W    = 8;
    localparam int DISC_BIT = 42;

    typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_t;

    function automatic logic [CNT_W-1:0] norm_count(input logic [CNT_W-1:0] f);
        return f == '0 ? 11'd1024 : f;
    endfunction

    // dword enables of the final output word of a D-dword completion
    function automatic logic [KEEP_W-1:0] tail_keep(input logic [CNT_W-1:0] d);
        return d[2:0] == 3'd0 ? 8'hFF : (8'd1 << d[2:0]) - 8'd1;
    endfunction

    // the last input beat leaves 1..5 dwords in the remnant that need a word of their own
    function automatic logic needs_flush(input logic [CNT_W-1:0] d);
        return d[2:0] != 3'd0 && d[2:0] <= 3'd5;
    endfunction

endpackage

// File: rtl/rc_gearbox256_if.sv
// rc_gearbox256_if: bundles the core-side AXI-S completion stream and the realigned user-side stream
//   slave  : gearbox view (consumes m_axis_rc_*, rc_ready; drives m_axis_rc_tready and rc_*)
//   master : environment view (the opposite directions)
interface rc_gearbox256_if;
    import rc_gearbox_pkg::*;

    logic [BEAT_W-1:0]  m_axis_rc_tdata;
    logic [TUSER_W-1:0] m_axis_rc_tuser;
    logic [KEEP_W-1:0]  m_axis_rc_tkeep;
    logic               m_axis_rc_tlast;
    logic               m_axis_rc_tvalid;
    logic               m_axis_rc_tready;

    logic [BEAT_W-1:0]  rc_data;
    logic [KEEP_W-1:0]  rc_keep;
    logic               rc_sop;
    logic               rc_last;
    logic               rc_valid;
    logic               rc_ready;
    logic [TAG_W-1:0]   rc_tag;
    logic [CNT_W-1:0]   rc_dword_count;
    logic [ST_W-1:0]    rc_status;
    logic               rc_err;

    modport slave (
        input  m_axis_rc_tdata, m_axis_rc_tuser, m_axis_rc_tkeep, m_axis_rc_tlast, m_axis_rc_tvalid, rc_ready,
        output m_axis_rc_tready, rc_data, rc_keep, rc_sop, rc_last, rc_valid,
               rc_tag, rc_dword_count, rc_status, rc_err
    );

    modport master (
        output m_axis_rc_tdata, m_axis_rc_tuser, m_axis_rc_tkeep, m_axis_rc_tlast, m_axis_rc_tvalid, rc_ready,
        input  m_axis_rc_tready, rc_data, rc_keep, rc_sop, rc_last, rc_valid,
               rc_tag, rc_dword_count, rc_status, rc_err
    );

endinterface

// File: rtl/rc_gearbox256.sv
// rc_gearbox256: strips the 3-dword completion descriptor and realigns the payload to dword 0
//   clk, rst : single clock, synchronous active-high reset
//   bus      : rc_gearbox256_if.slave (core-side m_axis_rc_* in, user-side rc_* out, registered)
//   RC_GEARBOX_ERR_DROP_EN : when defined, completions with a bad descriptor are consumed silently
module rc_gearbox256
    import rc_gearbox_pkg::*;
#(
    parameter int DATA_WIDTH = 256
) (
    input  logic            clk,
    input  logic            rst,
    rc_gearbox256_if.slave  bus
);

    localparam int RW = DATA_WIDTH - HDR_W;

    state_t            state, state_n;
    logic [RW-1:0]     rem, rem_n;
    logic              first, first_n;
    logic              drop, drop_n;
    logic [BEAT_W-1:0] data_n;
    logic [KEEP_W-1:0] keep_n;
    logic              sop_n, last_n, valid_n, err_n;
    logic [TAG_W-1:0]  tag_n;
    logic [CNT_W-1:0]  cnt_n;
    logic [ST_W-1:0]   st_n;
    logic [CNT_W-1:0]  hd_cnt;
    logic              hd_bad, disc, drop_now, accept, adv;
    logic              unused_in;

    assign adv    = !bus.rc_valid || bus.rc_ready;
    assign bus.m_axis_rc_tready = !rst && adv && state != FLUSH;
    assign accept = bus.m_axis_rc_tvalid && bus.m_axis_rc_tready;
    assign hd_cnt = norm_count(bus.m_axis_rc_tdata[CNT_LSB +: CNT_W]);
    assign hd_bad = |bus.m_axis_rc_tdata[EC_LSB +: EC_W] || |bus.m_axis_rc_tdata[ST_LSB +: ST_W]
                    || bus.m_axis_rc_tdata[POIS_BIT];
    assign disc   = bus.m_axis_rc_tuser[DISC_BIT];
    assign unused_in = ^{bus.m_axis_rc_tkeep, bus.m_axis_rc_tuser[TUSER_W-1:DISC_BIT+1],
                         bus.m_axis_rc_tuser[DISC_BIT-1:0]};

`ifdef RC_GEARBOX_ERR_DROP_EN
    assign drop_now = hd_bad;
`else
    assign drop_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        first_n = first;
        drop_n  = drop;
        valid_n = bus.rc_valid && !bus.rc_ready;
        data_n  = bus.rc_data;
        keep_n  = bus.rc_keep;
        sop_n   = bus.rc_sop;
        last_n  = bus.rc_last;
        tag_n   = bus.rc_tag;
        cnt_n   = bus.rc_dword_count;
        st_n    = bus.rc_status;
        err_n   = bus.rc_err;
        case (state)
            IDLE: if (accept) begin
                tag_n   = bus.m_axis_rc_tdata[TAG_LSB +: TAG_W];
                cnt_n   = hd_cnt;
                st_n    = bus.m_axis_rc_tdata[ST_LSB +: ST_W];
                err_n   = hd_bad || disc;
                rem_n   = bus.m_axis_rc_tdata[DATA_WIDTH-1:HDR_W];
                drop_n  = drop_now;
                first_n = 1'b1;
                if (hd_cnt <= 11'd5) begin
                    valid_n = !drop_now;
                    data_n  = {{HDR_W{1'b0}}, bus.m_axis_rc_tdata[DATA_WIDTH-1:HDR_W]};
                    keep_n  = tail_keep(hd_cnt);
                    sop_n   = 1'b1;
                    last_n  = 1'b1;
                end else begin
                    state_n = BODY;
                end
            end
            BODY: if (accept) begin
                // current beat's low 3 dwords complete the word started by the remnant
                rem_n   = bus.m_axis_rc_tdata[DATA_WIDTH-1:HDR_W];
                err_n   = bus.rc_err || disc;
                first_n = 1'b0;
                valid_n = !drop;
                data_n  = {bus.m_axis_rc_tdata[HDR_W-1:0], rem};
                sop_n   = first;
                keep_n  = 8'hFF;
                last_n  = 1'b0;
                if (bus.m_axis_rc_tlast) begin
                    if (drop || !needs_flush(bus.rc_dword_count)) begin
                        state_n = IDLE;
                        last_n  = 1'b1;
                        keep_n  = tail_keep(bus.rc_dword_count);
                    end else begin
                        state_n = FLUSH;
                    end
                end
            end
            FLUSH: if (adv) begin
                valid_n = 1'b1;
                data_n  = {{HDR_W{1'b0}}, rem};
                keep_n  = tail_keep(bus.rc_dword_count);
                sop_n   = 1'b0;
                last_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem                <= '0;
            first              <= 1'b0;
            drop               <= 1'b0;
            bus.rc_valid       <= 1'b0;
            bus.rc_data        <= '0;
            bus.rc_keep        <= '0;
            bus.rc_sop         <= 1'b0;
            bus.rc_last        <= 1'b0;
            bus.rc_tag         <= '0;
            bus.rc_dword_count <= '0;
            bus.rc_status      <= '0;
            bus.rc_err         <= 1'b0;
        end else begin
            rem                <= rem_n;
            first              <= first_n;
            drop               <= drop_n;
            bus.rc_valid       <= valid_n;
            bus.rc_data        <= data_n;
            bus.rc_keep        <= keep_n;
            bus.rc_sop         <= sop_n;
            bus.rc_last        <= last_n;
            bus.rc_tag         <= tag_n;
            bus.rc_dword_count <= cnt_n;
            bus.rc_status      <= st_n;
            bus.rc_err         <= err_n;
        end
    end

endmodule

// File: tb/tb_rc_gearbox256.sv
// tb_rc_gearbox256: randomized scoreboard bench for rc_gearbox256 against a dword-list reference model
module tb_rc_gearbox256;

    typedef struct {
        logic [255:0] data;
        logic [7:0]   keep;
        logic         sop;
        logic         last;
        logic [7:0]   tag;
        logic [10:0]  cnt;
        logic [2:0]   st;
        logic         err;
    } exp_t;

`ifdef RC_GEARBOX_ERR_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   rmode = 0;
    int   lo_cnt = 0;
    int   viol = 0;
    int   nword = 0;
    exp_t sb[$];

    rc_gearbox256_if bus();

    rc_gearbox256 #(.DATA_WIDTH(256)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // user-side backpressure: 0 = always ready, 1 = toggling 1010..., 2 = random
    initial bus.rc_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (rmode == 0)      bus.rc_ready = 1'b1;
        else if (rmode == 1) bus.rc_ready = ~bus.rc_ready;
        else                 bus.rc_ready = ($urandom_range(0, 2) != 0);
    end

    // monitor: pops the scoreboard on every transfer, checks hold and tready rules
    logic         prev_hold = 1'b0;
    logic [266:0] prev_word = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                tests++;
                if ({bus.rc_data, bus.rc_keep, bus.rc_sop, bus.rc_last, bus.rc_valid} !== prev_word) begin
                    fails++;
                    $display("FAIL hold: output changed while stalled, got %h expected %h",
                             {bus.rc_data, bus.rc_keep, bus.rc_sop, bus.rc_last, bus.rc_valid}, prev_word);
                end
            end
            prev_hold = bus.rc_valid && !bus.rc_ready;
            prev_word = {bus.rc_data, bus.rc_keep, bus.rc_sop, bus.rc_last, bus.rc_valid};
            if ((!bus.rc_valid || bus.rc_ready) && !bus.m_axis_rc_tready) lo_cnt++;
            if (bus.m_axis_rc_tready && bus.rc_valid && !bus.rc_ready) viol++;
            if (bus.rc_valid && bus.rc_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: data=%h keep=%h sop=%b last=%b, expected no word",
                             bus.rc_data, bus.rc_keep, bus.rc_sop, bus.rc_last);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.rc_data !== e.data || bus.rc_keep !== e.keep || bus.rc_sop !== e.sop ||
                        bus.rc_last !== e.last || bus.rc_tag !== e.tag || bus.rc_dword_count !== e.cnt ||
                        bus.rc_status !== e.st || bus.rc_err !== e.err) begin
                        fails++;
                        $display("FAIL word%0d: got data=%h keep=%h sop=%b last=%b tag=%h cnt=%0d st=%0d err=%b",
                                 nword, bus.rc_data, bus.rc_keep, bus.rc_sop, bus.rc_last, bus.rc_tag,
                                 bus.rc_dword_count, bus.rc_status, bus.rc_err);
                        $display("  word%0d expected data=%h keep=%h sop=%b last=%b tag=%h cnt=%0d st=%0d err=%b",
                                 nword, e.data, e.keep, e.sop, e.last, e.tag, e.cnt, e.st, e.err);
                    end
                end
                nword++;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_accept();
        int n = 0;
        bit ok = 1'b0;
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = bus.m_axis_rc_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: tready not seen in %0d cycles, expected within 1000", n);
        end
    endtask

    // d dwords of payload; disc = beat index carrying tuser discontinue (-1 none);
    // lim >= 0 sends only that many beats and expects nothing (packet cut by reset)
    task automatic send_pkt(input int d, input logic [3:0] ec, input logic [2:0] st,
                            input logic pois, input int disc, input int lim);
        logic [31:0]  s [0:1039];
        logic [31:0]  h0, h1, h2;
        logic [7:0]   tag;
        logic [255:0] td;
        logic [95:0]  r96;
        logic         bad;
        int           nb, nw;
        tag = 8'($urandom);
        h0 = $urandom; h0[15:12] = ec;
        h1 = $urandom; h1[10:0] = (d == 1024) ? 11'd0 : 11'(d); h1[13:11] = st; h1[14] = pois;
        h2 = $urandom; h2[7:0] = tag;
        for (int i = 0; i < 1040; i++) s[i] = 32'h0;
        s[0] = h0; s[1] = h1; s[2] = h2;
        for (int i = 0; i < d; i++) s[3 + i] = $urandom;
        nb  = (d + 3 + 7) / 8;
        nw  = (d + 7) / 8;
        bad = (ec != 0) || (st != 0) || pois;
        if (lim < 0 && !(bad && DROP)) begin
            for (int j = 0; j < nw; j++) begin
                exp_t e;
                e.data = '0;
                e.keep = '0;
                for (int i = 0; i < 8; i++) begin
                    if (8 * j + i < d) begin
                        e.data[32 * i +: 32] = s[3 + 8 * j + i];
                        e.keep[i] = 1'b1;
                    end
                end
                e.sop  = (j == 0);
                e.last = (j == nw - 1);
                e.tag  = tag;
                e.cnt  = 11'(d);
                e.st   = st;
                // word j is complete once beat j+1 arrives; a discontinue taints it and all later words
                e.err  = bad || (disc >= 0 && disc <= j + 1);
                sb.push_back(e);
            end
        end
        for (int k = 0; k < nb && (lim < 0 || k < lim); k++) begin
            for (int i = 0; i < 8; i++) td[32 * i +: 32] = s[8 * k + i];
            r96 = {$urandom, $urandom, $urandom};
            r96[42] = (k == disc);
            bus.m_axis_rc_tdata  = td;
            bus.m_axis_rc_tuser  = r96[74:0];
            bus.m_axis_rc_tkeep  = 8'($urandom);
            bus.m_axis_rc_tlast  = (k == nb - 1);
            bus.m_axis_rc_tvalid = 1'b1;
            wait_accept();
        end
    endtask

    task automatic idle();
        bus.m_axis_rc_tvalid = 1'b0;
        bus.m_axis_rc_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d words outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_ctl"}, {bus.m_axis_rc_tready, bus.rc_valid, bus.rc_sop, bus.rc_last, bus.rc_err,
                           bus.rc_keep, bus.rc_tag, bus.rc_dword_count, bus.rc_status}, 64'h0);
        chk({nm, "_data"}, 64'(bus.rc_data != '0), 64'h0);
    endtask

    initial begin
        int d, nb, disc, sel;
        logic [3:0] ec;
        logic [2:0] st;
        logic pois;
        bus.m_axis_rc_tdata  = '0;
        bus.m_axis_rc_tuser  = '0;
        bus.m_axis_rc_tkeep  = '0;
        bus.m_axis_rc_tlast  = 1'b0;
        bus.m_axis_rc_tvalid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // D=3 single beat, one clock latency
        rmode = 0;
        send_pkt(3, 4'h0, 3'h0, 1'b0, -1, -1);
        idle();
        @(negedge clk);
        chk("d3_latency", {bus.rc_valid, bus.rc_sop, bus.rc_last, bus.rc_keep}, {1'b1, 1'b1, 1'b1, 8'h07});
        drain();

        // D=8: no flush, tready never drops
        lo_cnt = 0;
        send_pkt(8, 4'h0, 3'h0, 1'b0, -1, -1);
        idle();
        drain();
        chk("d8_tready_low_cycles", 64'(lo_cnt), 64'd0);

        // D=13: flush word, tready low exactly once
        lo_cnt = 0;
        send_pkt(13, 4'h0, 3'h0, 1'b0, -1, -1);
        idle();
        drain();
        chk("d13_tready_low_cycles", 64'(lo_cnt), 64'd1);

        // two D=16 back-to-back under 1010 backpressure
        rmode = 1;
        send_pkt(16, 4'h0, 3'h0, 1'b0, -1, -1);
        send_pkt(16, 4'h0, 3'h0, 1'b0, -1, -1);
        idle();
        drain();

        // bad status, then a clean completion
        rmode = 0;
        send_pkt(4, 4'h0, 3'h1, 1'b0, -1, -1);
        send_pkt(5, 4'h0, 3'h0, 1'b0, -1, -1);
        idle();
        drain();

        // discontinue on a body beat of a flushed completion
        send_pkt(21, 4'h0, 3'h0, 1'b0, 2, -1);
        idle();
        drain();

        // reset inside a D=32 completion, then D=2
        send_pkt(32, 4'h0, 3'h0, 1'b0, -1, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        @(posedge clk); #1;
        send_pkt(2, 4'h0, 3'h0, 1'b0, -1, -1);
        idle();
        @(negedge clk);
        chk("d2_after_reset", {bus.rc_valid, bus.rc_sop, bus.rc_last, bus.rc_keep}, {1'b1, 1'b1, 1'b1, 8'h03});
        drain();

        // randomized traffic
        rmode = 2;
        for (int p = 0; p < 40; p++) begin
            d    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 1024)) : int'($urandom_range(1, 40));
            if (p == 7) d = 1024;
            nb   = (d + 10) / 8;
            sel  = $urandom_range(0, 9);
            ec   = (sel == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            st   = (sel == 1) ? 3'($urandom_range(1, 7)) : 3'h0;
            pois = (sel == 2);
            disc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            send_pkt(d, ec, st, pois, disc, -1);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        idle();
        drain();
        chk("tready_while_stalled", 64'(viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
